// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_serial_tx
//  Description : Pops bytes from an upstream synchronous FIFO and sends each
//                one as an asynchronous serial frame: start bit (0), data bits
//                LSB first, optional even-parity bit, stop bit (1). Each bit
//                lasts CLKS_PER_BIT clock cycles; the line idles high.
//                Optional feature macro: FIFO_SERIAL_TX_PARITY_EN
//                (defined -> a PARITY bit is sent between DATA and STOP).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  re,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5
`ifdef FIFO_SERIAL_TX_PARITY_EN
        ,
        S_PARITY = 3'd6
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [c_CNT_W-1:0]      cnt_q, cnt_d;
    logic [c_IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    w_bit_end;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign w_bit_end = (cnt_q == c_CNT_LAST);
    assign busy      = (state_q != S_IDLE);

    // State, counters and shift register; reset drops any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic and Moore outputs; counters restart on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        idx_d      = idx_q;
        shift_d    = shift_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        re         = 1'b0;
        tx         = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Gated by empty so this block can never underrun the FIFO.
                re      = !empty;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // FIFO read data is valid the cycle after the pop.
                shift_d  = r_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                parity_d = ^r_data;
`endif
                state_d  = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (w_bit_end) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            S_DATA: begin
                tx = shift_q[0];
                if (w_bit_end) begin
                    if (idx_q == c_IDX_LAST) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + c_IDX_ONE;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            S_PARITY: begin
                tx = parity_q;
                if (w_bit_end) begin
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                tx = 1'b1;
                if (w_bit_end) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            idx_d = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_serial_tx
//  Description : Directed self-checking bench for fifo_serial_tx with a small
//                synchronous FIFO model (CLKS_PER_BIT=4, DATA_WIDTH=8).
//                Parity frames are expected when FIFO_SERIAL_TX_PARITY_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_serial_tx;

    localparam int c_CPB = 4;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       empty;
    logic [7:0] r_data;
    logic       re;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // FIFO model: pushed by the stimulus, popped by the DUT read enable
    logic [7:0] mem [0:31];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         re_cnt = 0;
    int         fd_cnt = 0;

    assign empty = (wr_ptr == rd_ptr);

    fifo_serial_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (c_CPB)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .empty      (empty),
        .r_data     (r_data),
        .re         (re),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous FIFO read: data appears the cycle after re is sampled
    always @(posedge clk) begin
        if (re === 1'b1 && wr_ptr != rd_ptr) begin
            r_data <= mem[rd_ptr[4:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Pulse counters for re and frame_done
    always @(posedge clk) begin
        if (re === 1'b1)         re_cnt <= re_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[4:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Wait for a start bit, then check every cycle of the frame.
    task automatic check_frame(input logic [7:0] b, input int exp_gap, input int drop_k);
        logic [10:0] bits;
        int          nb;
        int          n;
        logic        found;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        nb   = 11;
        bits = {1'b1, ^b, b, 1'b0};
`else
        nb   = 10;
        bits = {1'b0, 1'b1, b, 1'b0};
`endif
        n     = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) found = 1'b1;
        end
        chk("start_found", {31'd0, found}, 32'd1);
        if (!found) return;
        if (exp_gap >= 0) chk("gap", n, exp_gap);
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < c_CPB; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (k == drop_k && c == 0) enable = 1'b0;
                chk("frame_tx", {31'd0, tx}, {31'd0, bits[k]});
                chk("frame_busy", {31'd0, busy}, 32'd1);
                chk("frame_done", {31'd0, frame_done},
                    (k == nb - 1 && c == c_CPB - 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    int re0;
    int fd0;

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        r_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_re", {31'd0, re}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Empty FIFO with enable high: nothing happens
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("empty_idle", {29'd0, re, busy, frame_done}, 32'd0);
        end

        // Single byte 0xA5
        re0 = re_cnt;
        fd0 = fd_cnt;
        push(8'hA5);
        check_frame(8'hA5, -1, -1);
        @(negedge clk);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);
        chk("a5_re_pulses", re_cnt - re0, 32'd1);
        chk("a5_fd_pulses", fd_cnt - fd0, 32'd1);

        // Three queued bytes back to back
        re0 = re_cnt;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        check_frame(8'h01, -1, -1);
        check_frame(8'h80, 4, -1);
        check_frame(8'hFF, 4, -1);
        @(negedge clk);
        chk("b2b_busy_after", {31'd0, busy}, 32'd0);
        chk("b2b_re_pulses", re_cnt - re0, 32'd3);

        // enable low with data waiting: no pop, line stays high
        enable = 1'b0;
        re0 = re_cnt;
        push(8'h3C);
        push(8'h5A);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("dis_re_tx", {30'd0, re, tx}, 32'd1);
        end
        chk("dis_re_pulses", re_cnt - re0, 32'd0);

        // enable dropped mid-frame (during DATA): frame completes, no more pops
        enable = 1'b1;
        check_frame(8'h3C, -1, 3);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("drop_idle", {29'd0, re, tx, busy}, 32'd2);
        end
        chk("drop_re_pulses", re_cnt - re0, 32'd1);

        // Reset mid-DATA: outputs return to idle at once, byte is dropped
        enable = 1'b1;
        begin : rst_mid
            int n;
            n = 0;
            while (tx !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("rst_mid_start", {31'd0, tx}, 32'd0);
        end
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_re", {31'd0, re}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {29'd0, re, tx, busy}, 32'd2);
        end

`ifdef FIFO_SERIAL_TX_PARITY_EN
        // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
        push(8'h07);
        push(8'h03);
        check_frame(8'h07, -1, -1);
        check_frame(8'h03, 4, -1);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: byte width popped from the upstream sync FIFO.
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16, legal range 2 to 65535: clk cycles per serial bit.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  permits starting a new frame.
REQ-006 SHALL have port empty  input  1  the FIFO empty flag.
REQ-007 SHALL have port r_data  input  DATA_WIDTH  the FIFO read data; valid the cycle after re is sampled high.
REQ-008 SHALL have port re  output  1  the FIFO read enable.
REQ-009 SHALL have port tx  output  1  serial line; idle high.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port frame_done  output  1  single-cycle pulse at the end of each stop bit.

Function
REQ-012 SHALL implement states IDLE, FETCH, LOAD, START, DATA, STOP, plus PARITY when configured (REQ-026).
REQ-013 SHALL go IDLE->FETCH when enable=1 and empty=0; otherwise SHALL stay in IDLE.
REQ-014 SHALL drive re=1 only during the single FETCH cycle; SHALL then go to LOAD unconditionally.
REQ-015 SHALL capture r_data into the shift register during LOAD, then go to START.
REQ-016 SHALL drive tx=0 for CLKS_PER_BIT cycles in START.
REQ-017 SHALL send DATA_WIDTH bits LSB first in DATA, each for CLKS_PER_BIT cycles.
REQ-018 SHALL drive tx=1 for CLKS_PER_BIT cycles in STOP.
REQ-019 SHALL pulse frame_done=1 in the last STOP cycle, then return to IDLE.
REQ-020 SHALL use a bit-period counter of width ceil(log2(CLKS_PER_BIT)) and a bit index counter; both clear on every state entry.
REQ-021 SHALL hold tx=1 in IDLE, FETCH and LOAD.
- Back-to-back frames are therefore separated by STOP plus 3 high cycles.
REQ-022 SHALL ignore empty and enable outside IDLE.
- Deasserting enable mid-frame completes the current frame; no new frame starts.
REQ-023 SHALL never assert re while empty=1, so FIFO underrun is impossible from this block.

Reset
REQ-024 SHALL, while rst=1, immediately force: state=IDLE, tx=1, re=0, busy=0, frame_done=0, counters=0, shift register=0.
REQ-025 SHALL drop a byte already popped when reset hits mid-frame (FETCH through STOP); no retransmission.

Configuration
REQ-026 SHALL honour macro FIFO_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state follows DATA, driving the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles before STOP.
- Undefined: no PARITY state; DATA goes directly to STOP; frame = 10 bit periods for DATA_WIDTH=8.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-027 Reset: rst=1 mid-DATA -> same cycle tx=1, busy=0, re=0; after release, state stays IDLE while empty=1.
REQ-028 Single byte 0xA5, enable=1, empty falls -> re high exactly 1 cycle; tx = 0 (4 cyc), bits 1,0,1,0,0,1,0,1 (4 cyc each), 1 (4 cyc); frame_done one pulse; 40 cycles START to STOP end.
REQ-029 FIFO holding 3 bytes 0x01, 0x80, 0xFF, enable=1 -> 3 frames in order, exactly 3 re pulses, 7 high cycles between consecutive start bits' preceding stop-start edges (4 stop + 3 idle).
REQ-030 enable=0 with empty=0 -> re never asserted, tx constant 1; enable dropped mid-frame -> frame finishes, no further re.
REQ-031 With FIFO_SERIAL_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after the data bits, 44-cycle frame; byte 0x03 -> parity 0.
REQ-032 empty=1 throughout 100 cycles with enable=1 -> re=0, busy=0, frame_done=0 for all cycles.
